// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer driving the shared EX-stage ALU.
// Shift-add multiply and restoring divide, one ALU pass per cycle over 32 cycles.
module alu_muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_code,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc holds hi (multiply) or rem (divide); sft holds lo or quo; opnd holds mcand or dvsr
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   sft_q, sft_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              carry;
  logic              ge;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   acc_nxt;
  logic [XLEN-1:0]   sft_nxt;

  always_comb begin
    carry   = 1'b0;
    ge      = 1'b0;
    sh      = {acc_q[XLEN-2:0], sft_q[XLEN-1]};
    acc_nxt = acc_q;
    sft_nxt = sft_q;
    if (!op_q[1]) begin
      carry = (alu_result < acc_q);
      if (sft_q[0]) begin
        acc_nxt = {carry, alu_result[XLEN-1:1]};
        sft_nxt = {alu_result[0], sft_q[XLEN-1:1]};
      end else begin
        acc_nxt = {1'b0, acc_q[XLEN-1:1]};
        sft_nxt = {acc_q[0], sft_q[XLEN-1:1]};
      end
    end else begin
      // a set rem MSB means the 33-bit shifted remainder always exceeds dvsr
      ge = acc_q[XLEN-1] | (sh >= opnd_q);
      if (ge) begin
        acc_nxt = alu_result;
        sft_nxt = {sft_q[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = sh;
        sft_nxt = {sft_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_code = 4'b0000;
    if (state_q == S_CALC) begin
      alu_b = opnd_q;
      if (!op_q[1]) begin
        alu_a    = acc_q;
        alu_code = 4'b0000;
      end else begin
        alu_a    = sh;
        alu_code = 4'b0001;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sft_d    = sft_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d   = op;
          cnt_d  = '0;
          acc_d  = '0;
          sft_d  = op[1] ? src_a : src_b;
          opnd_d = op[1] ? src_b : src_a;
          if (op[1] && (src_b == '0)) begin
            state_d  = S_DONE;
            result_d = op[0] ? src_a : '1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_nxt;
          sft_d = sft_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '1) begin
            state_d  = S_DONE;
            result_d = op_q[0] ? acc_nxt : sft_nxt;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sft_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sft_q    <= sft_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
